// File: rtl/avalon_pio_bank.sv
// avalon_pio_bank
//   Avalon-MM slave with a bank of double-buffered output channels and a
//   small edge-capturing key input port with a level interrupt.
//
//   Register map (word addresses):
//     0 .. NUM_CH-1  SHADOW[i]  staging value for channel i (DATA_W bits, zero-extended)
//     NUM_CH         CTRL       bit1 AUTO (r/w), bit0 COMMIT (write-1 pulse, reads 0)
//     NUM_CH+1       EDGE       captured rising edges of key_in, write 1 to clear
//     NUM_CH+2       MASK       interrupt enable per key bit
//     NUM_CH+3       INDATA     synchronized key_in (read only)
//     above          reads 0, writes ignored
//   Every writable register honours avs_byteenable.
//
//   Ports:
//     clk_clk, reset_reset_n        clock, async active-low reset
//     avs_address/read/write/...    Avalon-MM slave, fixed one-cycle read latency
//     avs_readdata/readdatavalid    read response
//     key_in                        asynchronous key inputs
//     irq                           registered OR(EDGE & MASK)
//     ch_export                     active channel values, channel i at [i*DATA_W +: DATA_W]
module avalon_pio_bank #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int IN_W   = 2,
  localparam int ADDR_W = $clog2(NUM_CH + 4)
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic [ADDR_W-1:0]        avs_address,
  input  logic                     avs_read,
  input  logic                     avs_write,
  input  logic [31:0]              avs_writedata,
  input  logic [3:0]               avs_byteenable,
  output logic [31:0]              avs_readdata,
  output logic                     avs_readdatavalid,
  input  logic [IN_W-1:0]          key_in,
  output logic                     irq,
  output logic [NUM_CH*DATA_W-1:0] ch_export
);

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(NUM_CH);
  localparam logic [ADDR_W-1:0] ADDR_EDGE   = ADDR_W'(NUM_CH + 1);
  localparam logic [ADDR_W-1:0] ADDR_MASK   = ADDR_W'(NUM_CH + 2);
  localparam logic [ADDR_W-1:0] ADDR_INDATA = ADDR_W'(NUM_CH + 3);

  logic [DATA_W-1:0] shadow_q      [NUM_CH];
  logic [DATA_W-1:0] active_q      [NUM_CH];
  logic [DATA_W-1:0] shadow_merged [NUM_CH];
  logic [NUM_CH-1:0] shadow_wr;

  logic              auto_q, auto_d;
  logic              wr_ctrl, wr_edge, wr_mask, commit;
  logic [31:0]       be_mask, ctrl_rd, rd_mux;
  logic [31:0]       rd_data_q;
  logic              rd_valid_q;
  logic              irq_q;

  logic [IN_W-1:0]   key_meta_q, key_sync_q, key_prev_q;
  logic [2:0]        sample_ok_q;
  logic [IN_W-1:0]   edge_q, mask_q, rise, edge_clr, edge_d, mask_d;

  // Bus handshake: no waitrequest, every request is accepted in the cycle
  // it is presented. A read presented in cycle N returns data in cycle N+1
  // with avs_readdatavalid high for exactly that cycle; readdata is forced
  // to 0 whenever readdatavalid is low. A read and write in the same cycle
  // are both performed and the read sees the value from before the write.

  assign be_mask = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}},
                    {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      shadow_wr[i]     = avs_write && (avs_address == ADDR_W'(i));
      // Bits at or above DATA_W fall away in the truncating cast.
      shadow_merged[i] = DATA_W'((32'(shadow_q[i]) & ~be_mask) | (avs_writedata & be_mask));
    end
  end

  assign wr_ctrl = avs_write && (avs_address == ADDR_CTRL);
  assign wr_edge = avs_write && (avs_address == ADDR_EDGE);
  assign wr_mask = avs_write && (avs_address == ADDR_MASK);
  assign commit  = wr_ctrl && avs_byteenable[0] && avs_writedata[0];
  assign auto_d  = (wr_ctrl && avs_byteenable[0]) ? avs_writedata[1] : auto_q;
  assign ctrl_rd = {30'd0, auto_q, 1'b0};

  // key_prev only holds a real synchronized sample from the third clock
  // after reset on; before that a key already high would look like a rise.
  assign rise     = sample_ok_q[2] ? (key_sync_q & ~key_prev_q) : '0;
  assign edge_clr = wr_edge ? IN_W'(avs_writedata & be_mask) : '0;
  // A fresh rise wins over a clear of the same bit.
  assign edge_d   = (edge_q & ~edge_clr) | rise;
  assign mask_d   = wr_mask ? IN_W'((32'(mask_q) & ~be_mask) | (avs_writedata & be_mask))
                            : mask_q;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (avs_address == ADDR_W'(i)) rd_mux = 32'(shadow_q[i]);
    end
    if (avs_address == ADDR_CTRL)   rd_mux = ctrl_rd;
    if (avs_address == ADDR_EDGE)   rd_mux = 32'(edge_q);
    if (avs_address == ADDR_MASK)   rd_mux = 32'(mask_q);
    if (avs_address == ADDR_INDATA) rd_mux = 32'(key_sync_q);
  end

  // Channel storage. Only one address is written per cycle, so a commit
  // never coincides with a shadow write and always copies settled values.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (shadow_wr[i]) shadow_q[i] <= shadow_merged[i];
        if (commit) active_q[i] <= shadow_q[i];
        else if (shadow_wr[i] && auto_q) active_q[i] <= shadow_merged[i];
      end
    end
  end

  // Control, key capture, interrupt and read response.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      auto_q      <= 1'b0;
      key_meta_q  <= '0;
      key_sync_q  <= '0;
      key_prev_q  <= '0;
      sample_ok_q <= '0;
      edge_q      <= '0;
      mask_q      <= '0;
      irq_q       <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      auto_q      <= auto_d;
      key_meta_q  <= key_in;
      key_sync_q  <= key_meta_q;
      key_prev_q  <= key_sync_q;
      sample_ok_q <= {sample_ok_q[1:0], 1'b1};
      edge_q      <= edge_d;
      mask_q      <= mask_d;
      irq_q       <= |(edge_q & mask_q);
      rd_valid_q  <= avs_read;
      rd_data_q   <= avs_read ? rd_mux : '0;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_export[g*DATA_W +: DATA_W] = active_q[g];
  end

  assign irq               = irq_q;
  assign avs_readdata      = rd_data_q;
  assign avs_readdatavalid = rd_valid_q;

endmodule

// File: tb/tb_avalon_pio_bank.sv
`timescale 1ns/1ps
module tb_avalon_pio_bank;

  localparam int NUM_CH = 5;
  localparam int DATA_W = 32;
  localparam int IN_W   = 2;
  localparam int ADDR_W = 4;
  localparam int A_CTRL = NUM_CH;
  localparam int A_EDGE = NUM_CH + 1;
  localparam int A_MASK = NUM_CH + 2;
  localparam int A_IN   = NUM_CH + 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0]        avs_address    = '0;
  logic                     avs_read       = 1'b0;
  logic                     avs_write      = 1'b0;
  logic [31:0]              avs_writedata  = '0;
  logic [3:0]               avs_byteenable = '0;
  logic [31:0]              avs_readdata;
  logic                     avs_readdatavalid;
  logic [IN_W-1:0]          key_in         = '0;
  logic                     irq;
  logic [NUM_CH*DATA_W-1:0] ch_export;

  // Narrow companion instance sharing the bus, used for the DATA_W=8 case.
  logic [31:0] rd8;
  logic        rdv8, irq8;
  logic [15:0] ch8;

  avalon_pio_bank #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .IN_W(IN_W)) u_dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .key_in(key_in), .irq(irq), .ch_export(ch_export)
  );

  avalon_pio_bank #(.NUM_CH(2), .DATA_W(8), .IN_W(1)) u_dut8 (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .avs_address(avs_address[2:0]), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(rd8), .avs_readdatavalid(rdv8),
    .key_in(key_in[0:0]), .irq(irq8), .ch_export(ch8)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]     m_shadow [NUM_CH];
  logic [31:0]     m_active [NUM_CH];
  logic            m_auto, m_irq, m_rd_valid;
  logic [IN_W-1:0] m_edge, m_mask;
  logic [IN_W-1:0] key_hist[$];   // key_in sampled at each clock since reset (last 3 kept)
  logic [31:0]     exp_q[$];      // expected read data, one entry per accepted read

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Synchronized key value = the sample taken two clocks ago.
  function automatic logic [IN_W-1:0] m_sync();
    if (key_hist.size() >= 2) return key_hist[key_hist.size()-2];
    return '0;
  endfunction

  function automatic logic [31:0] m_read(input int a);
    if (a < NUM_CH)  return m_shadow[a];
    if (a == A_CTRL) return {30'd0, m_auto, 1'b0};
    if (a == A_EDGE) return 32'(m_edge);
    if (a == A_MASK) return 32'(m_mask);
    if (a == A_IN)   return 32'(m_sync());
    return 32'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [IN_W-1:0] rise, clr;
    logic [31:0]     old_shadow [NUM_CH];
    int              a;
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_shadow[i] = '0;
        m_active[i] = '0;
      end
      m_auto = 0; m_irq = 0; m_rd_valid = 0; m_edge = '0; m_mask = '0;
      key_hist.delete();
      exp_q.delete();
    end else begin
      a          = int'(avs_address);
      old_shadow = m_shadow;
      // A rise needs two real synchronized samples: the current one and the one before.
      rise = (key_hist.size() >= 3) ?
             (key_hist[key_hist.size()-2] & ~key_hist[key_hist.size()-3]) : '0;
      m_irq      = |(m_edge & m_mask);
      m_rd_valid = avs_read;
      if (avs_read) exp_q.push_back(m_read(a));
      clr = '0;
      if (avs_write) begin
        if (a < NUM_CH) begin
          m_shadow[a] = merge(m_shadow[a], avs_writedata, avs_byteenable);
          if (m_auto) m_active[a] = m_shadow[a];
        end else if (a == A_CTRL && avs_byteenable[0]) begin
          if (avs_writedata[0]) m_active = old_shadow;
          m_auto = avs_writedata[1];
        end else if (a == A_EDGE && avs_byteenable[0]) begin
          clr = avs_writedata[IN_W-1:0];
        end else if (a == A_MASK && avs_byteenable[0]) begin
          m_mask = avs_writedata[IN_W-1:0];
        end
      end
      m_edge = (m_edge & ~clr) | rise;
      key_hist.push_back(key_in);
      if (key_hist.size() > 3) void'(key_hist.pop_front());
    end
  end

  // ---------------- per-cycle scoreboard ----------------
  logic chk_en = 1'b0;

  always @(negedge clk) begin : cmp
    logic [159:0] exp_ch;
    logic [31:0]  exp_rd;
    if (chk_en) begin
      exp_ch = '0;
      for (int i = 0; i < NUM_CH; i++) exp_ch[i*32 +: 32] = m_active[i];
      check("ch_export", ch_export, exp_ch);
      check("irq", irq, m_irq);
      check("rdvalid", avs_readdatavalid, m_rd_valid);
      exp_rd = 32'd0;
      if (m_rd_valid && exp_q.size() > 0) exp_rd = exp_q.pop_front();
      check("rddata", avs_readdata, exp_rd);
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input int a, input logic [31:0] d, input logic [3:0] be);
    avs_address = ADDR_W'(a); avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0; avs_byteenable = '0;
  endtask

  task automatic bus_read(input int a, output logic [31:0] d);
    avs_address = ADDR_W'(a); avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic read_check(input string name, input int a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check({name, "_valid"}, avs_readdatavalid, 1'b1);
    check(name, d, exp);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] d;
    rst_n = 1'b0;
    idle(3);
    chk_en = 1'b1;
    check("reset_ch", ch_export, '0);
    check("reset_irq", irq, 1'b0);
    check("reset_rdv", avs_readdatavalid, 1'b0);
    rst_n = 1'b1;
    idle(1);

    // Commit path
    bus_write(0, 32'h12345678, 4'hF);
    check("s1_ch0_hold", ch_export[31:0], 32'h0);
    bus_write(A_CTRL, 32'h1, 4'h1);
    check("s1_ch0_commit", ch_export[31:0], 32'h12345678);
    read_check("s1_ctrl", A_CTRL, 32'h0);

    // AUTO path with partial byte enables
    bus_write(A_CTRL, 32'h2, 4'h1);
    bus_write(1, 32'hAABBCCDD, 4'h3);
    check("s2_ch1", ch_export[63:32], 32'h0000CCDD);
    check("s2_ch0_kept", ch_export[31:0], 32'h12345678);
    read_check("s2_shadow1", 1, 32'h0000CCDD);
    idle(1);
    check("s2_rdv_drop", avs_readdatavalid, 1'b0);
    read_check("s2_ctrl", A_CTRL, 32'h2);
    for (int a = 0; a < NUM_CH + 4; a++) bus_read(a, d);   // back-to-back reads

    // Read and write to one address in the same cycle
    avs_address = 4'd3; avs_writedata = 32'h0BADF00D; avs_byteenable = 4'hF;
    avs_write = 1'b1; avs_read = 1'b1;
    @(negedge clk);
    avs_write = 1'b0; avs_read = 1'b0; avs_byteenable = '0;
    check("rw_old", avs_readdata, 32'h0);
    read_check("rw_new", 3, 32'h0BADF00D);

    // Out-of-range addresses and narrow channel width
    read_check("oob_read", NUM_CH + 5, 32'h0);
    bus_write(12, 32'hFFFFFFFF, 4'hF);
    read_check("oob_write", 12, 32'h0);
    bus_write(0, 32'h0000FFFF, 4'hF);
    bus_read(0, d);
    check("s5_main_sh0", d, 32'h0000FFFF);
    check("s5_w8_sh0", rd8, 32'h000000FF);
    bus_write(2, 32'h1, 4'hF);            // COMMIT on the narrow instance
    check("s5_w8_ch0", ch8[7:0], 8'hFF);

    // Edge capture and interrupt
    bus_write(A_MASK, 32'h1, 4'h1);
    key_in = 2'b01;
    idle(3);
    check("s3_irq_pre", irq, 1'b0);
    idle(1);
    check("s3_irq", irq, 1'b1);
    read_check("s3_edge", A_EDGE, 32'h1);
    read_check("s3_indata", A_IN, 32'h1);
    bus_write(A_EDGE, 32'h1, 4'h1);
    check("s3_irq_lag", irq, 1'b1);
    idle(1);
    check("s3_irq_clr", irq, 1'b0);
    read_check("s3_edge_clr", A_EDGE, 32'h0);

    // Clear coinciding with a new rise
    key_in = 2'b00;
    idle(4);
    key_in = 2'b01;
    idle(1);
    key_in = 2'b00;
    idle(6);
    check("s4_irq_set", irq, 1'b1);
    key_in = 2'b01;
    idle(2);
    bus_write(A_EDGE, 32'h1, 4'h1);       // lands on the clock of the new rise
    check("s4_irq_hold", irq, 1'b1);
    read_check("s4_edge", A_EDGE, 32'h1);
    check("s4_irq_hold2", irq, 1'b1);
    bus_write(A_EDGE, 32'h1, 4'h1);
    idle(2);
    check("s4_irq_off", irq, 1'b0);

    // Reset in the middle of a read, key held high across reset
    avs_address = 4'd0; avs_read = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("s6_ch", ch_export, '0);
    check("s6_irq", irq, 1'b0);
    check("s6_rdv", avs_readdatavalid, 1'b0);
    check("s6_rdata", avs_readdata, 32'h0);
    avs_read = 1'b0;
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    check("s6_no_rdv", avs_readdatavalid, 1'b0);
    idle(5);
    read_check("s6_edge", A_EDGE, 32'h0);
    read_check("s6_mask", A_MASK, 32'h0);
    read_check("s6_indata", A_IN, 32'h1);
    idle(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/avalon_pio_bank.md
AVALON_PIO_BANK -- requirements
Module: avalon_pio_bank

Interface
REQ-001 Parameter NUM_CH, default 4, number of output channels (1..16).
REQ-002 Parameter DATA_W, default 32, channel width in bits (1..32).
REQ-003 Parameter IN_W, default 2, key input width in bits (1..32).
REQ-004 Derived ADDR_W = clog2(NUM_CH+4).
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk_clk  input  1  sole clock; all flops on rising edge.
REQ-007 reset_reset_n  input  1  asynchronous active-low reset.
REQ-008 avs_address  input  ADDR_W  word address.
REQ-009 avs_read  input  1  read request.
REQ-010 avs_write  input  1  write request.
REQ-011 avs_writedata  input  32  write data.
REQ-012 avs_byteenable  input  4  per-byte write enable.
REQ-013 avs_readdata  output  32  read data.
REQ-014 avs_readdatavalid  output  1  one-cycle read-data qualifier.
REQ-015 key_in  input  IN_W  asynchronous key/button inputs.
REQ-016 irq  output  1  registered level interrupt.
REQ-017 ch_export  output  NUM_CH*DATA_W  active channel values; channel i at bits [i*DATA_W +: DATA_W].

Function
REQ-018 Register map: 0..NUM_CH-1 SHADOW[i]; NUM_CH CTRL; NUM_CH+1 EDGE; NUM_CH+2 MASK; NUM_CH+3 INDATA.
REQ-019 Addresses above NUM_CH+3 SHALL read 0; writes to them are ignored.
REQ-020 SHADOW write: update only enabled bytes; bits at or above DATA_W are discarded and read back as 0.
REQ-021 CTRL bit1 AUTO is read/write; CTRL bit0 COMMIT is write-1 pulse and always reads 0.
REQ-022 COMMIT write: every ACTIVE[i] takes SHADOW[i] on the following clock edge, so ch_export changes exactly one cycle after the write cycle.
REQ-023 If a SHADOW write and a COMMIT write coincide in the same cycle, the commit SHALL copy the pre-write shadow values.
REQ-024 AUTO=1: a SHADOW[i] write SHALL also load ACTIVE[i] with the newly merged value on the same edge; other channels are unchanged.
REQ-025 key_in SHALL pass through a 2-flop synchronizer; INDATA returns the synchronized value, zero-extended.
REQ-026 Synchronized 0->1 transition on bit k SHALL set EDGE[k]; writing 1 to EDGE[k] clears it.
REQ-027 A new edge in the same cycle as a clearing write SHALL leave EDGE[k] set.
REQ-028 MASK is read/write, IN_W bits; irq SHALL be registered as OR(EDGE & MASK), i.e. asserted one cycle after the EDGE/MASK update.
REQ-029 Read latency: avs_readdatavalid pulses exactly one cycle after avs_read, with avs_readdata valid in that cycle; avs_readdata is 0 whenever avs_readdatavalid is 0.
REQ-030 Simultaneous read and write to one address: both SHALL be performed, and the read returns the pre-write value.
REQ-031 Back-to-back reads every cycle SHALL be supported without stalls, with no waitrequest.

Reset
REQ-032 While reset_reset_n=0: SHADOW, ACTIVE, CTRL, EDGE, MASK, synchronizers, irq, avs_readdata and avs_readdatavalid are all 0; ch_export is 0.
REQ-033 A read pending when reset asserts SHALL be dropped, with no avs_readdatavalid after release.
REQ-034 The first synchronized sample after reset SHALL NOT generate an edge when key_in is already high.

Verification
REQ-035 Scenario 1: write SHADOW0=0x12345678 with byteenable 0xF and AUTO=0 -> ch_export ch0 stays 0; write CTRL=0x1 -> ch0=0x12345678 one cycle later.
REQ-036 Scenario 2: set AUTO=1, then write SHADOW1=0xAABBCCDD with byteenable 0x3 -> ch1=0x0000CCDD on the next cycle; read SHADOW1 -> 0x0000CCDD with readdatavalid one cycle after avs_read.
REQ-037 Scenario 3: MASK=0x1, then key_in[0] rises -> EDGE=0x1 after sync (3 cycles) and irq=1 one cycle later; write EDGE=0x1 -> irq=0 one cycle after EDGE clears.
REQ-038 Scenario 4: clearing write to EDGE in the same cycle as a new synchronized edge on bit 0 -> EDGE[0] remains 1 and irq stays 1.
REQ-039 Scenario 5: read address NUM_CH+5 -> 0x00000000; with DATA_W=8, write 0xFFFF to SHADOW0 -> reads back 0x000000FF.
REQ-040 Scenario 6: assert reset mid-read with channels loaded -> all outputs are 0 immediately, and no readdatavalid appears after release.
